// File: rtl/id_stage.sv
// id_stage: single-entry RV instruction decode stage.
// Splits a 32-bit instruction into its fields, classifies the format,
// builds the sign-extended immediate, and holds the result in an output
// register until downstream takes it. Also keeps two statistics counters.
//
// Handshake: a transfer happens on a rising edge where the valid side and
// the ready side are both high. in_ready may depend on out_ready in the
// same cycle, so downstream may use its ready to let a new instruction in
// while the current one leaves. While out_valid is high and out_ready is
// low, every output holds its value. flush drops the held instruction,
// and any instruction offered in the same cycle. A dropped instruction
// never counts as a transfer out.
module id_stage #(
    parameter int XLEN      = 32,
    parameter bit EN_ATOMIC = 1'b1,
    parameter bit EN_SYSTEM = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      input_instruction,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       opcode,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [2:0]       func3,
    output logic [6:0]       func7,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       op_type,
    output logic             illegal,
    output logic [CNT_W-1:0] decoded_count,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [2:0] OP_R   = 3'd0;
    localparam logic [2:0] OP_I   = 3'd1;
    localparam logic [2:0] OP_S   = 3'd2;
    localparam logic [2:0] OP_B   = 3'd3;
    localparam logic [2:0] OP_U   = 3'd4;
    localparam logic [2:0] OP_J   = 3'd5;
    localparam logic [2:0] OP_ILL = 3'd7;

    logic             r_out_valid;
    logic [6:0]       r_opcode;
    logic [4:0]       r_rd;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [2:0]       r_func3;
    logic [6:0]       r_func7;
    logic [XLEN-1:0]  r_imm;
    logic [2:0]       r_op_type;
    logic             r_illegal;
    logic [CNT_W-1:0] r_decoded_count;
    logic [CNT_W-1:0] r_illegal_count;

    logic             w_in_ready;
    logic             w_xfer_in;
    logic             w_xfer_out;
    logic [2:0]       w_op_type;
    logic             w_illegal;
    logic [31:0]      w_imm32;
    logic [XLEN-1:0]  w_imm;

    // Stage is free when empty or draining; flush and reset block new input.
    always_comb begin
        w_in_ready = (!r_out_valid || out_ready) && !flush && rst_n;
        w_xfer_in  = in_valid && w_in_ready;
        w_xfer_out = r_out_valid && out_ready && !flush;
    end

    // Classify the instruction format from its opcode.
    always_comb begin
        w_op_type = OP_ILL;
        w_illegal = 1'b1;
        case (input_instruction[6:0])
            7'b0110011: begin
                w_op_type = OP_R;
                w_illegal = 1'b0;
            end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                w_op_type = OP_I;
                w_illegal = 1'b0;
            end
            7'b0100011: begin
                w_op_type = OP_S;
                w_illegal = 1'b0;
            end
            7'b1100011: begin
                w_op_type = OP_B;
                w_illegal = 1'b0;
            end
            7'b0010111, 7'b0110111: begin
                w_op_type = OP_U;
                w_illegal = 1'b0;
            end
            7'b1101111: begin
                w_op_type = OP_J;
                w_illegal = 1'b0;
            end
            7'b1110011: begin
                if (EN_SYSTEM) begin
                    w_op_type = OP_I;
                    w_illegal = 1'b0;
                end
            end
            7'b0101111: begin
                if (EN_ATOMIC) begin
                    w_op_type = OP_R;
                    w_illegal = 1'b0;
                end
            end
            default: begin
                w_op_type = OP_ILL;
                w_illegal = 1'b1;
            end
        endcase
    end

    // Assemble the 32-bit immediate, then sign-extend bit 31 up to XLEN.
    always_comb begin
        w_imm32 = 32'd0;
        case (w_op_type)
            OP_I: w_imm32 = {{20{input_instruction[31]}}, input_instruction[31:20]};
            OP_S: w_imm32 = {{20{input_instruction[31]}}, input_instruction[31:25],
                             input_instruction[11:7]};
            OP_B: w_imm32 = {{20{input_instruction[31]}}, input_instruction[7],
                             input_instruction[30:25], input_instruction[11:8], 1'b0};
            OP_U: w_imm32 = {input_instruction[31:12], 12'd0};
            OP_J: w_imm32 = {{12{input_instruction[31]}}, input_instruction[19:12],
                             input_instruction[20], input_instruction[30:21], 1'b0};
            default: w_imm32 = 32'd0;
        endcase
        w_imm = '0;
        w_imm[31:0] = w_imm32;
        for (int i = 32; i < XLEN; i++) begin
            w_imm[i] = w_imm32[31];
        end
    end

    // Output register and counters; reset beats flush, flush beats input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid     <= 1'b0;
            r_opcode        <= '0;
            r_rd            <= '0;
            r_rs1           <= '0;
            r_rs2           <= '0;
            r_func3         <= '0;
            r_func7         <= '0;
            r_imm           <= '0;
            r_op_type       <= '0;
            r_illegal       <= 1'b0;
            r_decoded_count <= '0;
            r_illegal_count <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else begin
            if (w_xfer_out) begin
                r_decoded_count <= r_decoded_count + CNT_W'(1);
                if (r_illegal && (r_illegal_count != {CNT_W{1'b1}})) begin
                    r_illegal_count <= r_illegal_count + CNT_W'(1);
                end
            end
            if (w_xfer_in) begin
                r_out_valid <= 1'b1;
                r_opcode    <= input_instruction[6:0];
                r_rd        <= input_instruction[11:7];
                r_func3     <= input_instruction[14:12];
                r_rs1       <= input_instruction[19:15];
                r_rs2       <= input_instruction[24:20];
                r_func7     <= input_instruction[31:25];
                r_imm       <= w_imm;
                r_op_type   <= w_op_type;
                r_illegal   <= w_illegal;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready      = w_in_ready;
    assign out_valid     = r_out_valid;
    assign opcode        = r_opcode;
    assign rd            = r_rd;
    assign rs1           = r_rs1;
    assign rs2           = r_rs2;
    assign func3         = r_func3;
    assign func7         = r_func7;
    assign imm           = r_imm;
    assign op_type       = r_op_type;
    assign illegal       = r_illegal;
    assign decoded_count = r_decoded_count;
    assign illegal_count = r_illegal_count;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed checks of id_stage.
// u_dut32 uses default parameters; u_dut64 uses XLEN=64, EN_ATOMIC=0 and
// 2-bit counters so wrap and saturation are reachable in a short run.
module tb_id_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] input_instruction;

    logic        a_in_ready, a_out_valid, a_illegal;
    logic [6:0]  a_opcode, a_func7;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [2:0]  a_func3, a_op_type;
    logic [31:0] a_imm;
    logic [15:0] a_dec, a_ill;

    logic        b_in_ready, b_out_valid, b_illegal;
    logic [6:0]  b_opcode, b_func7;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [2:0]  b_func3, b_op_type;
    logic [63:0] b_imm;
    logic [1:0]  b_dec, b_ill;

    int n_checks;
    int n_fails;

    id_stage u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(a_in_ready), .input_instruction(input_instruction),
        .out_valid(a_out_valid), .out_ready(out_ready), .opcode(a_opcode),
        .rd(a_rd), .rs1(a_rs1), .rs2(a_rs2), .func3(a_func3), .func7(a_func7),
        .imm(a_imm), .op_type(a_op_type), .illegal(a_illegal),
        .decoded_count(a_dec), .illegal_count(a_ill)
    );

    id_stage #(.XLEN(64), .EN_ATOMIC(1'b0), .EN_SYSTEM(1'b1), .CNT_W(2)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(b_in_ready), .input_instruction(input_instruction),
        .out_valid(b_out_valid), .out_ready(out_ready), .opcode(b_opcode),
        .rd(b_rd), .rs1(b_rs1), .rs2(b_rs2), .func3(b_func3), .func7(b_func7),
        .imm(b_imm), .op_type(b_op_type), .illegal(b_illegal),
        .decoded_count(b_dec), .illegal_count(b_ill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
        in_valid          = v;
        input_instruction = ins;
        out_ready         = ordy;
        flush             = fl;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n = 1'b0;
        drive(1'b1, 32'hFFF1_0093, 1'b1, 1'b0);
        step();
        #1;
        check_val("rst_in_ready", a_in_ready, 0);
        check_val("rst_out_valid", a_out_valid, 0);
        check_val("rst_dec", a_dec, 0);
        check_val("rst_ill", a_ill, 0);
        check_val("rst_imm", a_imm, 0);
        check_val("rst_opcode", a_opcode, 0);

        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        check_val("idle_out_valid", a_out_valid, 0);

        // addi x1,x2,-1
        drive(1'b1, 32'hFFF1_0093, 1'b1, 1'b0);
        #1 check_val("in_ready_empty", a_in_ready, 1);
        step();
        check_val("addi_valid", a_out_valid, 1);
        check_val("addi_type", a_op_type, 1);
        check_val("addi_rd", a_rd, 1);
        check_val("addi_rs1", a_rs1, 2);
        check_val("addi_f3", a_func3, 0);
        check_val("addi_imm32", a_imm, 64'hFFFF_FFFF);
        check_val("addi_imm64", b_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check_val("addi_dec_before", a_dec, 0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        check_val("addi_drained", a_out_valid, 0);
        check_val("addi_dec_after", a_dec, 1);

        // sw x5,8(x2)
        drive(1'b1, 32'h0051_2423, 1'b1, 1'b0);
        step();
        check_val("sw_type", a_op_type, 2);
        check_val("sw_rs1", a_rs1, 2);
        check_val("sw_rs2", a_rs2, 5);
        check_val("sw_f3", a_func3, 2);
        check_val("sw_imm", a_imm, 8);
        // beq x0,x0,-4 back to back
        drive(1'b1, 32'hFE00_0EE3, 1'b1, 1'b0);
        step();
        check_val("beq_type", a_op_type, 3);
        check_val("beq_imm", a_imm, 64'hFFFF_FFFC);
        check_val("beq_dec", a_dec, 2);
        // lui x3,0x12345
        drive(1'b1, 32'h1234_51B7, 1'b1, 1'b0);
        step();
        check_val("lui_type", b_op_type, 4);
        check_val("lui_rd", b_rd, 3);
        check_val("lui_imm64", b_imm, 64'h0000_0000_1234_5000);
        check_val("lui_dec", a_dec, 3);
        drive(1'b1, 32'h8000_00B7, 1'b1, 1'b0);
        step();
        check_val("luineg_imm64", b_imm, 64'hFFFF_FFFF_8000_0000);
        check_val("luineg_imm32", a_imm, 64'h8000_0000);
        check_val("dec32_4", a_dec, 4);
        check_val("dec64_wrap", b_dec, 0);

        // Stall three cycles with a new instruction waiting
        drive(1'b1, 32'h00A0_0093, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("stall_in_ready", a_in_ready, 0);
            step();
            check_val("stall_valid", a_out_valid, 1);
            check_val("stall_imm", a_imm, 64'h8000_0000);
            check_val("stall_rd", a_rd, 1);
            check_val("stall_dec", a_dec, 4);
        end
        out_ready = 1'b1;
        #1 check_val("release_in_ready", a_in_ready, 1);
        step();
        check_val("next_imm", a_imm, 10);
        check_val("next_type", a_op_type, 1);
        check_val("next_dec", a_dec, 5);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        check_val("next_drained", a_out_valid, 0);
        check_val("next_dec_after", a_dec, 6);

        // Illegal opcodes
        drive(1'b1, 32'h0000_007F, 1'b1, 1'b0);
        step();
        check_val("ill7f_flag", a_illegal, 1);
        check_val("ill7f_type", a_op_type, 7);
        check_val("ill7f_imm", a_imm, 0);
        check_val("ill7f_opcode", a_opcode, 7'h7F);
        drive(1'b1, 32'h0000_002F, 1'b1, 1'b0);
        step();
        check_val("amo32_type", a_op_type, 0);
        check_val("amo32_ill", a_illegal, 0);
        check_val("amo64_type", b_op_type, 7);
        check_val("amo64_ill", b_illegal, 1);
        check_val("ill32_cnt1", a_ill, 1);
        check_val("ill64_cnt1", b_ill, 1);
        drive(1'b1, 32'h0000_0000, 1'b1, 1'b0);
        step();
        check_val("ill32_cnt1b", a_ill, 1);
        check_val("ill64_cnt2", b_ill, 2);
        drive(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        step();
        check_val("illff_type", a_op_type, 7);
        check_val("illff_rd", a_rd, 31);
        check_val("ill32_cnt2", a_ill, 2);
        check_val("ill64_cnt3", b_ill, 3);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        check_val("ill32_cnt3", a_ill, 3);
        check_val("ill64_sat", b_ill, 3);
        check_val("dec32_10", a_dec, 10);
        check_val("dec64_10", b_dec, 2);

        // Flush drops an offered instruction
        drive(1'b1, 32'hFFF1_0093, 1'b1, 1'b1);
        #1 check_val("flush_in_ready", a_in_ready, 0);
        step();
        check_val("flush_drop_valid", a_out_valid, 0);
        check_val("flush_drop_dec", a_dec, 10);
        // Flush drops a held instruction
        drive(1'b1, 32'hFFF1_0093, 1'b0, 1'b0);
        step();
        check_val("flush_held_valid", a_out_valid, 1);
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        step();
        check_val("flush_held_cleared", a_out_valid, 0);
        check_val("flush_held_dec", a_dec, 10);
        check_val("flush_held_ill", a_ill, 3);
        flush = 1'b0;

        // Reset while holding a stalled illegal instruction
        drive(1'b1, 32'h0000_007F, 1'b0, 1'b0);
        step();
        check_val("pre_rst_valid", a_out_valid, 1);
        rst_n = 1'b0;
        drive(1'b1, 32'hFFF1_0093, 1'b0, 1'b1);
        step();
        check_val("midrst_valid", a_out_valid, 0);
        check_val("midrst_dec", a_dec, 0);
        check_val("midrst_ill", a_ill, 0);
        check_val("midrst_imm", a_imm, 0);
        check_val("midrst_illegal", a_illegal, 0);
        check_val("midrst_type", a_op_type, 0);
        check_val("midrst_opcode", a_opcode, 0);
        check_val("midrst_dec64", b_dec, 0);
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        check_val("postrst_valid", a_out_valid, 0);
        check_val("postrst_dec", a_dec, 0);
        check_val("postrst_ill", a_ill, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
